key_debounce8: RTL and testbench

KEY_DEBOUNCE8 -- requirements
Module: key_debounce8

---
 rtl/key_debounce8_pkg.sv | 16 +
 rtl/key_debounce_cell.sv | 63 ++++++
 rtl/key_debounce8.sv | 62 ++++++
 tb/tb_key_debounce8.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce8_pkg.sv
// Shared constants for the 8-key debouncer that feeds the 8-3 priority encoder.
// Key lines are active-low, so the idle (nothing pressed) vector is all ones.
package key_debounce8_pkg;

  localparam int DEF_TICK_DIV     = 1000;
  localparam int DEF_STABLE_TICKS = 4;
  localparam int NUM_KEYS         = 8;

  localparam logic [NUM_KEYS-1:0] KEYS_IDLE = 8'hFF;

  // Counter width for a modulo-n counter; a divide-by-1 still needs one bit.
  function automatic int cntWidth(input int modulus);
    return (modulus <= 1) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchronizer, tick-qualified stability counter and
// registered press/release pulses that trail the debounced level by a cycle.
module key_debounce_cell
  import key_debounce8_pkg::*;
#(
  parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iKey,
  input  logic iTick,
  output logic oKey,
  output logic oPress,
  output logic oRelease
);

  localparam int CNT_W = $clog2(STABLE_TICKS + 1);

  logic             syncMetaReg;
  logic             syncKeyReg;
  logic [CNT_W-1:0] stableCntReg;
  logic [CNT_W-1:0] stableCntNext;
  logic             keyDlyReg;

  assign stableCntNext = stableCntReg + CNT_W'(1);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      syncMetaReg  <= IDLE_LEVEL;
      syncKeyReg   <= IDLE_LEVEL;
      stableCntReg <= '0;
      oKey         <= IDLE_LEVEL;
      keyDlyReg    <= IDLE_LEVEL;
      oPress       <= 1'b0;
      oRelease     <= 1'b0;
    end else begin
      syncMetaReg <= iKey;
      syncKeyReg  <= syncMetaReg;

      // Any tick that agrees with the accepted level restarts the count,
      // so a bounce must persist STABLE_TICKS ticks in a row to be taken.
      if (iTick) begin
        if (syncKeyReg != oKey) begin
          if (stableCntNext == CNT_W'(STABLE_TICKS)) begin
            oKey         <= syncKeyReg;
            stableCntReg <= '0;
          end else begin
            stableCntReg <= stableCntNext;
          end
        end else begin
          stableCntReg <= '0;
        end
      end

      // keyDlyReg resets to idle alongside oKey, so reset never fakes an edge.
      keyDlyReg <= oKey;
      oPress    <= keyDlyReg & ~oKey;
      oRelease  <= ~keyDlyReg & oKey;
    end
  end

endmodule

// File: rtl/key_debounce8.sv
// Eight independent key debouncers sharing one sample-tick divider, plus the
// registered active-low strobe for the downstream priority encoder.
module key_debounce8
  import key_debounce8_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [NUM_KEYS-1:0] iKeys,
  input  logic                iEn,
  output logic [NUM_KEYS-1:0] oKeys,
  output logic                oEI,
  output logic [NUM_KEYS-1:0] oPress,
  output logic [NUM_KEYS-1:0] oRelease
);

  localparam int TICK_W = cntWidth(TICK_DIV);

  logic [TICK_W-1:0] tickCntReg;
  logic              tick;

  assign tick = (tickCntReg == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge iClk) begin
    if (iRst) begin
      tickCntReg <= '0;
    end else if (tick) begin
      tickCntReg <= '0;
    end else begin
      tickCntReg <= tickCntReg + TICK_W'(1);
    end
  end

  // The enable only gates the encoder; debouncing keeps running underneath.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oEI <= 1'b1;
    end else begin
      oEI <= ~iEn;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : genKey
      key_debounce_cell #(
        .STABLE_TICKS (STABLE_TICKS),
        .IDLE_LEVEL   (KEYS_IDLE[gi])
      ) uCell (
        .iClk     (iClk),
        .iRst     (iRst),
        .iKey     (iKeys[gi]),
        .iTick    (tick),
        .oKey     (oKeys[gi]),
        .oPress   (oPress[gi]),
        .oRelease (oRelease[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce8.sv
// Directed scenarios followed by random key traffic, every cycle compared
// against a behavioural model built from integer counters and delay history.
module tb_key_debounce8;

  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;

  logic       clk = 1'b0;
  logic       iRst;
  logic [7:0] iKeys;
  logic       iEn;
  logic [7:0] oKeys;
  logic       oEI;
  logic [7:0] oPress;
  logic [7:0] oRelease;

  int total = 0;
  int bad   = 0;

  key_debounce8 #(
    .TICK_DIV     (TICK_DIV),
    .STABLE_TICKS (STABLE_TICKS)
  ) dut (
    .iClk     (clk),
    .iRst     (iRst),
    .iKeys    (iKeys),
    .iEn      (iEn),
    .oKeys    (oKeys),
    .oEI      (oEI),
    .oPress   (oPress),
    .oRelease (oRelease)
  );

  always #5 clk = ~clk;

  // Model: raw input seen two edges late, tick every TICK_DIV-th edge since
  // reset, per-key run length of disagreeing ticks, pulses one cycle late.
  logic [7:0] seen1, seen2;
  int         phase;
  int         runLen [8];
  logic [7:0] mKeys, mKeysPrev, mPress, mRel;
  logic       mEi;

  function automatic void modelEdge();
    logic [7:0] nextKeys;
    if (iRst) begin
      seen1 = 8'hFF; seen2 = 8'hFF; phase = 0;
      for (int k = 0; k < 8; k++) runLen[k] = 0;
      mKeys = 8'hFF; mKeysPrev = 8'hFF; mPress = 8'h00; mRel = 8'h00; mEi = 1'b1;
    end else begin
      nextKeys = mKeys;
      if (phase == TICK_DIV - 1) begin
        for (int k = 0; k < 8; k++) begin
          if (seen2[k] != mKeys[k]) begin
            runLen[k] = runLen[k] + 1;
            if (runLen[k] == STABLE_TICKS) begin
              nextKeys[k] = seen2[k];
              runLen[k] = 0;
            end
          end else begin
            runLen[k] = 0;
          end
        end
      end
      phase     = (phase + 1) % TICK_DIV;
      mPress    = mKeysPrev & ~mKeys;
      mRel      = ~mKeysPrev & mKeys;
      mKeysPrev = mKeys;
      mKeys     = nextKeys;
      seen2     = seen1;
      seen1     = iKeys;
      mEi       = ~iEn;
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    chk("model_keys", oKeys, mKeys);
    chk("model_press", oPress, mPress);
    chk("model_release", oRelease, mRel);
    chk("model_ei", {7'b0, oEI}, {7'b0, mEi});
  endtask

  task automatic waitKeys(input string tag, input logic [7:0] target, input int limit);
    int n;
    n = 0;
    while (n < limit && oKeys !== target) begin
      step();
      n++;
    end
    chk(tag, oKeys, target);
    $display("wait %s: oKeys=%h after %0d cycles", tag, oKeys, n);
  endtask

  initial begin
    logic [7:0] pressSeen, relSeen, keysSeen;
    int hold;

    // Reset with keys all pressed: outputs must still show idle.
    iRst = 1'b1; iKeys = 8'h00; iEn = 1'b1;
    step();
    step();
    chk("rst_keys", oKeys, 8'hFF);
    chk("rst_press", oPress, 8'h00);
    chk("rst_release", oRelease, 8'h00);
    chk("rst_ei", {7'b0, oEI}, 8'h01);
    iRst = 1'b0; iKeys = 8'hFF;
    for (int i = 0; i < 6; i++) step();
    chk("idle_ei", {7'b0, oEI}, 8'h00);

    // Clean single press and release of key 2.
    iKeys = 8'hFB;
    waitKeys("press_lat", 8'hFB, 15);
    step();
    chk("press_pulse", oPress, 8'h04);
    step();
    chk("press_once", oPress, 8'h00);
    iKeys = 8'hFF;
    waitKeys("release_lat", 8'hFF, 15);
    step();
    chk("release_pulse", oRelease, 8'h04);
    step();
    chk("release_once", oRelease, 8'h00);
    for (int i = 0; i < 6; i++) step();

    // Key 0 bouncing every 5 cycles never qualifies.
    pressSeen = 8'h00; relSeen = 8'h00; keysSeen = 8'hFF;
    for (int seg = 0; seg < 8; seg++) begin
      iKeys[0] = ~iKeys[0];
      for (int i = 0; i < 5; i++) begin
        step();
        pressSeen |= oPress; relSeen |= oRelease; keysSeen &= oKeys;
      end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      pressSeen |= oPress; relSeen |= oRelease; keysSeen &= oKeys;
    end
    chk("bounce_keys", keysSeen, 8'hFF);
    chk("bounce_press", pressSeen, 8'h00);
    chk("bounce_release", relSeen, 8'h00);

    // Keys 7 and 0 pressed together land on the same cycle.
    iKeys = 8'h7E;
    waitKeys("simul_lat", 8'h7E, 15);
    step();
    chk("simul_press", oPress, 8'h81);
    iKeys = 8'hFF;
    waitKeys("simul_rel_lat", 8'hFF, 15);
    step();
    chk("simul_release", oRelease, 8'h81);
    for (int i = 0; i < 6; i++) step();

    // Reset in the middle of a count, key 3 still held afterwards.
    iKeys = 8'hF7;
    for (int i = 0; i < 8; i++) step();
    chk("midrst_pending", oKeys, 8'hFF);
    iRst = 1'b1;
    step();
    step();
    chk("midrst_keys", oKeys, 8'hFF);
    chk("midrst_press", oPress, 8'h00);
    iRst = 1'b0;
    waitKeys("midrst_relatch", 8'hF7, 15);
    step();
    chk("midrst_repress", oPress, 8'h08);
    step();
    chk("midrst_once", oPress, 8'h00);
    iKeys = 8'hFF;
    waitKeys("midrst_release", 8'hFF, 15);
    for (int i = 0; i < 4; i++) step();

    // Enable toggling drives only the strobe, one cycle late.
    iEn = 1'b0;
    step();
    chk("en_off_ei", {7'b0, oEI}, 8'h01);
    chk("en_off_keys", oKeys, 8'hFF);
    step();
    iEn = 1'b1;
    step();
    chk("en_on_ei", {7'b0, oEI}, 8'h00);
    chk("en_on_keys", oKeys, 8'hFF);

    // Random traffic: held patterns, short glitches, enables and resets.
    for (int t = 0; t < 400; t++) begin
      iKeys = 8'($urandom);
      iEn   = ($urandom_range(0, 3) != 0);
      iRst  = ($urandom_range(0, 39) == 0);
      hold  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 30);
      for (int i = 0; i < hold; i++) begin
        step();
        iRst = 1'b0;
      end
    end
    iKeys = 8'hFF;
    waitKeys("final_idle", 8'hFF, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
